// File: rtl/stego_pkg.sv
// Shared constants and FSM state type for the stego embed/extract chain.
package stego_pkg;

    localparam int unsigned EMBED_POS_DEFAULT = 2;
    localparam int unsigned SYM_W             = 4;
    localparam int unsigned BYTE_W            = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/stego_extractor_if.sv
// Image-byte, key-write and symbol handshakes between the extractor and its neighbours.
interface stego_extractor_if #(
    parameter int unsigned NUM_SYMBOLS = 2976,
    parameter int unsigned NUM_KEY     = 208,
    parameter int unsigned SYM_BITS    = stego_pkg::SYM_W
);
    localparam int unsigned KA_W = $clog2(NUM_KEY);
    localparam int unsigned SI_W = $clog2(NUM_SYMBOLS);

    logic                          start;
    logic                          key_we;
    logic [KA_W-1:0]               key_waddr;
    logic [SYM_BITS-1:0]           key_wdata;
    logic                          pix_valid;
    logic [stego_pkg::BYTE_W-1:0]  pix_data;
    logic                          pix_ready;
    logic                          sym_valid;
    logic [SYM_BITS-1:0]           sym_data;
    logic [SI_W-1:0]               sym_index;
    logic                          sym_ready;
    logic                          busy;
    logic                          done;

    modport master (
        output start, key_we, key_waddr, key_wdata, pix_valid, pix_data, sym_ready,
        input  pix_ready, sym_valid, sym_data, sym_index, busy, done
    );

    modport slave (
        input  start, key_we, key_waddr, key_wdata, pix_valid, pix_data, sym_ready,
        output pix_ready, sym_valid, sym_data, sym_index, busy, done
    );
endinterface

// File: rtl/stego_key_rom.sv
// Key nibble register file: synchronous write, combinational read (old data on same-cycle write).
module stego_key_rom #(
    parameter int unsigned NUM_KEY = 208,
    parameter int unsigned W       = 4,
    parameter int unsigned AW      = $clog2(NUM_KEY)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata_c
);

    logic [W-1:0] mem_q [NUM_KEY];
    logic [W-1:0] mem_d [NUM_KEY];

    always_comb begin
        mem_d = mem_q;
        if (we && (32'(waddr) < NUM_KEY)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Contents survive reset on purpose.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/stego_extractor.sv
// Pulls one payload bit per stego byte, packs LSB-first symbols and XOR-decrypts them with a cyclic key.
module stego_extractor
    import stego_pkg::*;
#(
    parameter int unsigned EMBED_POS    = EMBED_POS_DEFAULT,
    parameter int unsigned BITS_PER_SYM = SYM_W,
    parameter int unsigned NUM_SYMBOLS  = 2976,
    parameter int unsigned NUM_KEY      = 208
) (
    input  logic               clk,
    input  logic               reset,
    stego_extractor_if.slave   bus
);

    localparam int unsigned SIDX_W = $clog2(NUM_SYMBOLS);
    localparam int unsigned KIDX_W = $clog2(NUM_KEY);
    localparam int unsigned BCNT_W = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;

    state_e                  state_q, state_d;
    logic [BCNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [BITS_PER_SYM-1:0] shift_q, shift_d;
    logic [SIDX_W-1:0]       symcnt_q, symcnt_d;
    logic [KIDX_W-1:0]       kidx_q, kidx_d;
    logic                    sym_valid_q, sym_valid_d;
    logic [BITS_PER_SYM-1:0] sym_data_q, sym_data_d;
    logic [SIDX_W-1:0]       sym_index_q, sym_index_d;
    logic                    last_pend_q, last_pend_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [BITS_PER_SYM-1:0] key_c;
    logic [BITS_PER_SYM-1:0] asm_c;
    logic                    pix_ready_c;
    logic                    accept_c;
    logic                    complete_c;
    logic                    out_hs_c;
    logic                    enter_run_c;

    stego_key_rom #(
        .NUM_KEY (NUM_KEY),
        .W       (BITS_PER_SYM),
        .AW      (KIDX_W)
    ) u_key_rom (
        .clk     (clk),
        .we      (bus.key_we),
        .waddr   (bus.key_waddr),
        .wdata   (bus.key_wdata),
        .raddr   (kidx_q),
        .rdata_c (key_c)
    );

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        symcnt_d    = symcnt_q;
        kidx_d      = kidx_q;
        sym_valid_d = sym_valid_q;
        sym_data_d  = sym_data_q;
        sym_index_d = sym_index_q;
        last_pend_d = last_pend_q;
        enter_run_c = 1'b0;

        // The output register may refill in the same cycle it is drained.
        out_hs_c    = sym_valid_q && bus.sym_ready;
        pix_ready_c = (state_q == RUN) && !(sym_valid_q && !bus.sym_ready) && !last_pend_q;
        accept_c    = bus.pix_valid && pix_ready_c;
        asm_c       = shift_q;
        asm_c[bitcnt_q] = bus.pix_data[EMBED_POS];
        complete_c  = accept_c && (bitcnt_q == BCNT_W'(BITS_PER_SYM - 1));

        case (state_q)
            IDLE: if (bus.start) enter_run_c = 1'b1;
            DONE: if (bus.start) enter_run_c = 1'b1;
            RUN: begin
                if (out_hs_c) begin
                    sym_valid_d = 1'b0;
                    if (last_pend_q && (sym_index_q == SIDX_W'(NUM_SYMBOLS - 1))) begin
                        state_d = DONE;
                    end
                end
                if (accept_c) begin
                    shift_d  = asm_c;
                    bitcnt_d = complete_c ? '0 : bitcnt_q + BCNT_W'(1);
                end
                if (complete_c) begin
                    sym_valid_d = 1'b1;
                    sym_data_d  = asm_c ^ key_c;
                    sym_index_d = symcnt_q;
                    symcnt_d    = symcnt_q + SIDX_W'(1);
                    kidx_d      = (kidx_q == KIDX_W'(NUM_KEY - 1)) ? '0 : kidx_q + KIDX_W'(1);
                    if (symcnt_q == SIDX_W'(NUM_SYMBOLS - 1)) last_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_run_c) begin
            state_d     = RUN;
            bitcnt_d    = '0;
            shift_d     = '0;
            symcnt_d    = '0;
            kidx_d      = '0;
            sym_valid_d = 1'b0;
            last_pend_d = 1'b0;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            symcnt_q    <= '0;
            kidx_q      <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            sym_index_q <= '0;
            last_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            symcnt_q    <= symcnt_d;
            kidx_q      <= kidx_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            sym_index_q <= sym_index_d;
            last_pend_q <= last_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.pix_ready = pix_ready_c;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_data  = sym_data_q;
    assign bus.sym_index = sym_index_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
